// File: rtl/types_pkg.sv
// Shared types for the multi-cycle RV32I control path: state and ALU encodings,
// opcode constants and the immediate-format decode.
package types_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } ctrl_state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Immediate format is a pure function of the opcode, independent of state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_LOAD:   imm = 2'b00;
            OP_I:      imm = 2'b00;
            OP_STORE:  imm = 2'b01;
            OP_BRANCH: imm = 2'b10;
            OP_JAL:    imm = 2'b11;
            default:   imm = 2'b00;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decode for R- and I-type execute cycles; yields ADD when not enabled.
module alu_decoder
    import types_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       alu_en,
    output alu_ctrl_t  ALUControl
);

    // funct7b5 selects SUB only for R-type; for addi it is immediate bits.
    always_comb begin
        ALUControl = ALU_ADD;
        if (alu_en) begin
            case (funct3)
                3'b000: begin
                    if ((op == OP_R) && funct7b5) ALUControl = ALU_SUB;
                    else                          ALUControl = ALU_ADD;
                end
                3'b001: ALUControl = ALU_SLL;
                3'b010: ALUControl = ALU_SLT;
                3'b011: ALUControl = ALU_SLTU;
                3'b100: ALUControl = ALU_XOR;
                3'b101: begin
                    if (funct7b5) ALUControl = ALU_SRA;
                    else          ALUControl = ALU_SRL;
                end
                3'b110: ALUControl = ALU_OR;
                3'b111: ALUControl = ALU_AND;
                default: ALUControl = ALU_ADD;
            endcase
        end else begin
            ALUControl = ALU_ADD;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencing controller for the multi-cycle RV32I core: one state register,
// all strobes and selects decoded combinationally, shared memory via req/ready.
module multicycle_ctrl
    import types_pkg::*;
(
    input  logic       clk,
    input  logic       Reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] ResultSrc,
    output logic       illegal_instr,
    output logic [3:0] state_o
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    logic        alu_en_s;
    alu_ctrl_t   alu_dec_s;

    assign alu_en_s = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);

    alu_decoder u_alu_decoder (
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .alu_en     (alu_en_s),
        .ALUControl (alu_dec_s)
    );

    // State register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        MemWrite      = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUControl    = ALU_ADD;
        ResultSrc     = 2'b00;
        illegal_instr = 1'b0;
        ImmSrc        = imm_src_of(op);

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
                else           state_d = S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECUTER;
                    OP_I:              state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
                        state_d       = S_FETCH;
                        illegal_instr = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                if (op == OP_LOAD) state_d = S_MEMREAD;
                else               state_d = S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
                else           state_d = S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) state_d = S_FETCH;
                else           state_d = S_MEMWRITE;
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec_s;
                state_d    = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec_s;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                case (funct3)
                    3'b000:  PCWrite = Zero;
                    3'b001:  PCWrite = ~Zero;
                    default: PCWrite = 1'b0;
                endcase
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Gate combinationally so a write coinciding with reset assertion is suppressed.
        if (!Reset) begin
            mem_req       = 1'b0;
            MemWrite      = 1'b0;
            IRWrite       = 1'b0;
            PCWrite       = 1'b0;
            RegWrite      = 1'b0;
            illegal_instr = 1'b0;
            state_d       = S_FETCH;
        end else begin
            state_d = state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: steps instructions through the sequencer
// and checks state and strobes against hand-computed values.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       Reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal_instr;
    logic [1:0] ALUSrcA, ALUSrcB, ImmSrc, ResultSrc;
    logic [3:0] ALUControl, state_o;

    int errors = 0;
    int checks = 0;

    multicycle_ctrl dut (
        .clk           (clk),
        .Reset         (Reset),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .Zero          (Zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .MemWrite      (MemWrite),
        .AdrSrc        (AdrSrc),
        .IRWrite       (IRWrite),
        .PCWrite       (PCWrite),
        .RegWrite      (RegWrite),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ALUControl    (ALUControl),
        .ImmSrc        (ImmSrc),
        .ResultSrc     (ResultSrc),
        .illegal_instr (illegal_instr),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        #1;
    endtask

    // From FETCH with mem_ready=1: walk an R/I instruction through execute and writeback.
    task automatic run_alu(input string tag, input logic [3:0] exp_state, input logic [3:0] exp_alu,
                           input logic [1:0] exp_srcb);
        chk({tag, "_fetch_state"}, state_o, 4'd0);
        tick();
        chk({tag, "_decode_state"}, state_o, 4'd1);
        chk({tag, "_decode_regwrite"}, 4'(RegWrite), 4'd0);
        tick();
        chk({tag, "_exec_state"}, state_o, exp_state);
        chk({tag, "_exec_alu"}, ALUControl, exp_alu);
        chk({tag, "_exec_srca"}, 4'(ALUSrcA), 4'd2);
        chk({tag, "_exec_srcb"}, 4'(ALUSrcB), 4'(exp_srcb));
        chk({tag, "_exec_regwrite"}, 4'(RegWrite), 4'd0);
        tick();
        chk({tag, "_wb_state"}, state_o, 4'd8);
        chk({tag, "_wb_regwrite"}, 4'(RegWrite), 4'd1);
        chk({tag, "_wb_resultsrc"}, 4'(ResultSrc), 4'd0);
        tick();
        chk({tag, "_back_fetch"}, state_o, 4'd0);
    endtask

    initial begin
        Reset = 1'b0; mem_ready = 1'b1; Zero = 1'b0;
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;

        // Reset held: FETCH with write strobes and request suppressed.
        #2;
        chk("rst_state", state_o, 4'd0);
        chk("rst_mem_req", 4'(mem_req), 4'd0);
        chk("rst_irwrite", 4'(IRWrite), 4'd0);
        chk("rst_pcwrite", 4'(PCWrite), 4'd0);
        chk("rst_srcb", 4'(ALUSrcB), 4'd2);
        tick();
        chk("rst_hold_state", state_o, 4'd0);
        Reset = 1'b1;
        #1;
        chk("rel_mem_req", 4'(mem_req), 4'd1);
        chk("rel_irwrite", 4'(IRWrite), 4'd1);
        chk("rel_pcwrite", 4'(PCWrite), 4'd1);
        chk("rel_resultsrc", 4'(ResultSrc), 4'd2);

        // add, sub, srai, addi with bit30 set, sltu.
        set_instr(7'b0110011, 3'b000, 1'b0); run_alu("add",  4'd6, 4'b0000, 2'b00);
        set_instr(7'b0110011, 3'b000, 1'b1); run_alu("sub",  4'd6, 4'b0001, 2'b00);
        set_instr(7'b0010011, 3'b101, 1'b1); run_alu("srai", 4'd7, 4'b1001, 2'b01);
        set_instr(7'b0010011, 3'b000, 1'b1); run_alu("addi", 4'd7, 4'b0000, 2'b01);
        set_instr(7'b0110011, 3'b011, 1'b0); run_alu("sltu", 4'd6, 4'b0110, 2'b00);
        set_instr(7'b0110011, 3'b110, 1'b0); run_alu("or",   4'd6, 4'b0011, 2'b00);

        // FETCH stall: no IR/PC write while memory is not ready.
        set_instr(7'b0000011, 3'b010, 1'b0);
        mem_ready = 1'b0; #1;
        chk("fstall_irwrite", 4'(IRWrite), 4'd0);
        tick();
        chk("fstall_state", state_o, 4'd0);
        chk("fstall_mem_req", 4'(mem_req), 4'd1);
        mem_ready = 1'b1; #1;
        chk("lw_immsrc", 4'(ImmSrc), 4'd0);
        tick();
        chk("lw_decode", state_o, 4'd1);
        tick();
        chk("lw_memadr", state_o, 4'd2);
        chk("lw_memadr_srca", 4'(ALUSrcA), 4'd2);
        chk("lw_memadr_mem_req", 4'(mem_req), 4'd0);
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("lw_memread_state", state_o, 4'd3);
            chk("lw_memread_req", 4'(mem_req), 4'd1);
            chk("lw_memread_adrsrc", 4'(AdrSrc), 4'd1);
            chk("lw_memread_regwrite", 4'(RegWrite), 4'd0);
        end
        mem_ready = 1'b1; #1;
        chk("lw_memread_req3", 4'(mem_req), 4'd1);
        chk("lw_memread_adrsrc3", 4'(AdrSrc), 4'd1);
        tick();
        chk("lw_memwb_state", state_o, 4'd4);
        chk("lw_memwb_regwrite", 4'(RegWrite), 4'd1);
        chk("lw_memwb_resultsrc", 4'(ResultSrc), 4'd1);
        chk("lw_memwb_mem_req", 4'(mem_req), 4'd0);
        tick();
        chk("lw_back_fetch", state_o, 4'd0);

        // sw with mem_ready=1: 4 cycles.
        set_instr(7'b0100011, 3'b010, 1'b0);
        chk("sw_immsrc", 4'(ImmSrc), 4'd1);
        tick(); tick();
        chk("sw_memadr", state_o, 4'd2);
        tick();
        chk("sw_memwrite_state", state_o, 4'd5);
        chk("sw_memwrite", 4'(MemWrite), 4'd1);
        chk("sw_adrsrc", 4'(AdrSrc), 4'd1);
        tick();
        chk("sw_back_fetch", state_o, 4'd0);

        // beq taken, bne not taken and taken, blt-class funct3 never writes PC.
        set_instr(7'b1100011, 3'b000, 1'b0); Zero = 1'b1;
        chk("beq_immsrc", 4'(ImmSrc), 4'd2);
        tick(); tick();
        chk("beq_state", state_o, 4'd9);
        chk("beq_pcwrite", 4'(PCWrite), 4'd1);
        chk("beq_alu", ALUControl, 4'b0001);
        tick();
        chk("beq_back_fetch", state_o, 4'd0);
        set_instr(7'b1100011, 3'b001, 1'b0);
        tick(); tick();
        chk("bne_z1_pcwrite", 4'(PCWrite), 4'd0);
        Zero = 1'b0; #1;
        chk("bne_z0_pcwrite", 4'(PCWrite), 4'd1);
        tick();
        chk("bne_back_fetch", state_o, 4'd0);
        set_instr(7'b1100011, 3'b100, 1'b0);
        tick(); tick();
        chk("blt_pcwrite", 4'(PCWrite), 4'd0);
        tick();

        // jal.
        set_instr(7'b1101111, 3'b000, 1'b0);
        chk("jal_immsrc", 4'(ImmSrc), 4'd3);
        tick(); tick();
        chk("jal_state", state_o, 4'd10);
        chk("jal_pcwrite", 4'(PCWrite), 4'd1);
        chk("jal_srca", 4'(ALUSrcA), 4'd1);
        chk("jal_srcb", 4'(ALUSrcB), 4'd2);
        chk("jal_regwrite", 4'(RegWrite), 4'd0);
        tick();
        chk("jal_wb_regwrite", 4'(RegWrite), 4'd1);
        tick();
        chk("jal_back_fetch", state_o, 4'd0);

        // Unsupported opcode.
        set_instr(7'b1111111, 3'b000, 1'b0);
        chk("ill_fetch_pulse", 4'(illegal_instr), 4'd0);
        tick();
        chk("ill_decode_pulse", 4'(illegal_instr), 4'd1);
        chk("ill_regwrite", 4'(RegWrite), 4'd0);
        chk("ill_pcwrite", 4'(PCWrite), 4'd0);
        tick();
        chk("ill_back_fetch", state_o, 4'd0);
        chk("ill_pulse_gone", 4'(illegal_instr), 4'd0);

        // Reset asserted during a writeback strobe suppresses the write.
        set_instr(7'b0110011, 3'b000, 1'b0);
        tick(); tick(); tick();
        chk("rwb_regwrite_pre", 4'(RegWrite), 4'd1);
        Reset = 1'b0; #1;
        chk("rwb_regwrite", 4'(RegWrite), 4'd0);
        chk("rwb_state", state_o, 4'd0);
        tick();
        Reset = 1'b1; #1;

        // Reset during a stalled store.
        set_instr(7'b0100011, 3'b010, 1'b0);
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        chk("rsw_memwrite_pre", 4'(MemWrite), 4'd1);
        Reset = 1'b0; #1;
        chk("rsw_state", state_o, 4'd0);
        chk("rsw_memwrite", 4'(MemWrite), 4'd0);
        chk("rsw_mem_req", 4'(mem_req), 4'd0);
        tick();
        chk("rsw_hold_mem_req", 4'(mem_req), 4'd0);
        chk("rsw_hold_memwrite", 4'(MemWrite), 4'd0);
        Reset = 1'b1; #1;
        chk("rsw_rel_mem_req", 4'(mem_req), 4'd1);
        chk("rsw_rel_irwrite", 4'(IRWrite), 4'd0);
        mem_ready = 1'b1;
        tick();
        chk("rsw_refetch_decode", state_o, 4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style sequencing controller for the multi-cycle RV32I core variant. It decodes the latched instruction fields and steps a state machine that drives every datapath strobe and mux select: PC/IR write enables, memory address source, ALU operand selects, ALU operation, immediate format, result select and register-file write. It also waits on a shared instruction/data memory through a req/ready handshake.

## Interface
Parameters:
- none; widths come from `types_pkg` (`XLEN`, `ctrl_state_t`, `alu_ctrl_t`).

Ports:
- `clk`  in  1  rising-edge clock
- `Reset`  in  1  asynchronous, active-low reset
- `op`  in  7  instr[6:0] from IR
- `funct3`  in  3  instr[14:12]
- `funct7b5`  in  1  instr[30]
- `Zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access request
- `MemWrite`  out  1  the access is a store
- `AdrSrc`  out  1  0 = PC, 1 = Result
- `IRWrite`, `PCWrite`, `RegWrite`  out  1 each  register enables
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = A reg
- `ALUSrcB`  out  2  00 = WriteData, 01 = ImmExt, 10 = constant 4
- `ALUControl`  out  4  `alu_ctrl_t`
- `ImmSrc`  out  2  00 = I, 01 = S, 10 = B, 11 = J
- `ResultSrc`  out  2  00 = ALUOut, 01 = read data, 10 = ALUResult
- `illegal_instr`  out  1  one-cycle pulse on an unsupported opcode
- `state_o`  out  4  current state, for debug

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL.
- FETCH
  - Outputs: mem_req = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ADD, ResultSrc = 10.
  - IRWrite = PCWrite = mem_ready.
  - Holds while mem_ready = 0; moves to DECODE on mem_ready.
- DECODE
  - Outputs: ALUSrcA = 01, ALUSrcB = 01, ADD (branch target into ALUOut).
  - Next state by op: 0000011/0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BRANCH; 1101111 → JAL.
  - Any other op → FETCH with illegal_instr = 1.
- MEMADR
  - Outputs: ALUSrcA = 10, ALUSrcB = 01, ADD.
  - Next: MEMREAD for load, MEMWRITE for store.
- MEMREAD
  - Outputs: mem_req = 1, AdrSrc = 1, ResultSrc = 00.
  - Holds until mem_ready, then MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1; next FETCH.
- MEMWRITE
  - Outputs: mem_req = 1, MemWrite = 1, AdrSrc = 1, ResultSrc = 00.
  - Holds until mem_ready, then FETCH.
- EXECUTER: ALUSrcA = 10, ALUSrcB = 00, decoded ALU op; next ALUWB.
- EXECUTEI: ALUSrcA = 10, ALUSrcB = 01, decoded ALU op; next ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1; next FETCH.
- BRANCH
  - Outputs: ALUSrcA = 10, ALUSrcB = 00, SUB, ResultSrc = 00.
  - PCWrite = Zero when funct3 = 000 (beq); PCWrite = ~Zero when funct3 = 001 (bne); any other funct3 gives PCWrite = 0.
  - Next FETCH.
- JAL: ALUSrcA = 01, ALUSrcB = 10, ADD, ResultSrc = 00, PCWrite = 1; next ALUWB (writes PC+4 to rd).
- ImmSrc is decoded from op in every state: load/I-type → 00, store → 01, branch → 10, jal → 11, otherwise 00.
- ALU decode, used in EXECUTER/EXECUTEI only:
  - funct3 000: SUB if R-type and funct7b5, else ADD.
  - 001 SLL; 010 SLT; 100 XOR; 110 OR; 111 AND.
  - 101: SRA if funct7b5, else SRL (applies to both R and I).
  - 011: SLTU.
- Any strobe not listed for a state is 0. ALUControl defaults to ADD.

## Timing
- State register only; all outputs are combinational from state, op/funct, Zero and mem_ready.
- Reset low: state = FETCH immediately. While Reset is low, mem_req, MemWrite, IRWrite, PCWrite, RegWrite and illegal_instr are forced to 0. Other outputs take their FETCH values.
- First request: mem_req rises combinationally once Reset deasserts; the first edge with mem_ready = 1 fetches.
- Cycle counts with mem_ready always 1:
  - lw: 5
  - sw: 4
  - R/I-type: 4
  - beq/bne: 3
  - jal: 4
- Each mem_ready = 0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Handshake: mem_req, AdrSrc and MemWrite are held stable until the cycle in which mem_ready = 1. mem_ready is ignored while mem_req = 0.
- Reset mid-instruction: the instruction is abandoned and no further writes occur. If Reset falls in the same cycle as a RegWrite or PCWrite strobe, that write must not occur.
- illegal_instr is high only during the DECODE cycle.

## Structure
- Add to `types_pkg`:
  - `ctrl_state_t` enum (4-bit).
  - `alu_ctrl_t` enum: ADD = 0000, SUB = 0001, AND = 0010, OR = 0011, XOR = 0100, SLT = 0101, SLTU = 0110, SLL = 0111, SRL = 1000, SRA = 1001.
  - Opcode constants `OP_LOAD`, `OP_STORE`, `OP_R`, `OP_I`, `OP_BRANCH`, `OP_JAL`.
- One combinational sub-module, `alu_decoder`: inputs op, funct3, funct7b5, and an `alu_en` flag; output ALUControl.

## Test plan
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), mem_ready = 1: FETCH→DECODE→EXECUTER→ALUWB→FETCH. ALUControl = 0000 in EXECUTER; RegWrite high only in cycle 4.
- lw with mem_ready low 2 cycles in MEMREAD: mem_req and AdrSrc = 1 held 3 cycles; RegWrite with ResultSrc = 01 on the following cycle; 7 cycles total.
- beq with Zero = 1 → PCWrite = 1 in BRANCH; bne with Zero = 1 → PCWrite = 0; both return to FETCH after 3 cycles.
- jal: PCWrite in JAL with ALUSrcA = 01, ALUSrcB = 10; RegWrite in ALUWB; ImmSrc = 11.
- op 1111111: illegal_instr pulses one cycle in DECODE, no writes, back to FETCH.
- Reset low during MEMWRITE with mem_ready = 0: state_o = FETCH at once, MemWrite and mem_req = 0 while reset is held; fetch restarts after release.
